// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin_to_bcd_seq_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits per BCD digit
  localparam int DIGIT_W = 4;

  // Digits at or above this value get +3 before each shift
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // Minimum decimal digits needed to hold any WIDTH-bit value:
  // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point.
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Single-digit double-dabble correction: adds 3 to digits of 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Pre-shift correction so the following left shift lands on a valid BCD digit
  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Latency: WIDTH+1 cycles from the edge sampling start to the done cycle.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // With enough digits the top digit can never carry out, so overflow is constant 0
  localparam bit CAN_OVERFLOW = (DIGITS < min_digits(WIDTH));

  // Elaboration-time parameter range checks
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH=%0d outside legal range 4..32", WIDTH);
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d outside legal range 1..10", DIGITS);
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               last_shift;

  // {carry_out, next working digits, next shift register}
  logic               carry_out;
  logic [BCD_W-1:0]   work_nxt;
  logic [WIDTH-1:0]   shreg_nxt;

  // One add-3 corrector per working digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[g*DIGIT_W +: DIGIT_W]),
      .dout (work_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign {carry_out, work_nxt, shreg_nxt} = {work_adj, shreg_q, 1'b0};
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Shift/correct datapath, iteration counter and sticky overflow accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      shreg_q   <= bin;
      work_q    <= '0;
      cnt_q     <= CNT_W'(WIDTH);
      ovf_acc_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      shreg_q   <= shreg_nxt;
      work_q    <= work_nxt;
      cnt_q     <= cnt_q - CNT_W'(1);
      ovf_acc_q <= ovf_acc_q | carry_out;
    end
  end

  // Result registers load on the final shift so they are valid in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last_shift) begin
      bcd_q <= work_nxt;
      ovf_q <= ovf_acc_q | carry_out;
    end
  end

  // Result outputs
  always_comb begin
    bcd      = bcd_q;
    overflow = CAN_OVERFLOW ? ovf_q : 1'b0;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 5-digit instance plus a 4-digit overflow instance.
// Latency: checks WIDTH+1 cycle conversion time.
// Backpressure: checks that start is dropped while busy.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, overflow;
  logic [19:0] bcd;

  logic        start4 = 1'b0;
  logic [15:0] bin4 = '0;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
  );

  // Reference decimal digits by repeated division
  function automatic logic [19:0] to_bcd(input int value);
    logic [19:0] r;
    int v;
    v = value;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Pulse start for one cycle, scramble bin afterwards, wait (bounded) for done.
  // Returns at the negedge of the done cycle; lat=17 means done in cycle WIDTH+1.
  task automatic run_conv(input bit sel, input logic [15:0] v, output int lat);
    @(negedge clk);
    if (sel) begin start4 = 1'b1; bin4 = v; end
    else     begin start  = 1'b1; bin  = v; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    bin = ~v; bin4 = ~v;
    lat = 1;
    while (!(sel ? done4 : done) && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || bcd !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h, required 0 0 0 00000",
               busy, done, overflow, bcd);
    end
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 1'b0 || bcd4 !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state4: busy=%b done=%b ovf=%b bcd=%h, required 0 0 0 0000",
               busy4, done4, ovf4, bcd4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat;
    // start raised on the cycle right after reset release
    @(negedge clk);
    start = 1'b1; bin = 16'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; bin = 16'hffff;
    lat = 1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_start_accepted: busy=%b, required 1", busy);
    end
    while (!done && lat < 60) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    vectors++;
    if (lat !== 17) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d cycles, required 17", lat);
    end
    vectors++;
    if (bcd !== 20'h00000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_result: bcd=%h ovf=%b, required 00000 0", bcd, overflow);
    end
  endtask

  task automatic test_max_and_49();
    int lat;
    run_conv(1'b0, 16'd65535, lat);
    vectors++;
    if (lat !== 17 || bcd !== 20'h65535 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL max_value: lat=%0d bcd=%h ovf=%b, required 17 65535 0", lat, bcd, overflow);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
    end
    run_conv(1'b0, 16'd49, lat);
    vectors++;
    if (lat !== 17 || bcd !== 20'h00049 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL value_49: lat=%0d bcd=%h ovf=%b, required 17 00049 0", lat, bcd, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int cycles, idle;
    logic [19:0] prev;
    bit held_bad;
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd0;
    prev  = bcd;
    for (int v = 0; v < 50; v++) begin
      cycles = 0; idle = 0; held_bad = 1'b0;
      do begin
        @(posedge clk);
        @(negedge clk);
        cycles++;
        if (!busy) idle++;
        if (!done && bcd !== prev) held_bad = 1'b1;
      end while (!done && cycles < 60);
      vectors++;
      if (bcd !== to_bcd(v) || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_value v=%0d: bcd=%h ovf=%b, required %h 0", v, bcd, overflow, to_bcd(v));
      end
      vectors++;
      if (cycles !== ((v == 0) ? 17 : 18) || idle !== ((v == 0) ? 0 : 1)) begin
        miscompares++;
        $display("FAIL sweep_timing v=%0d: cycles=%0d idle=%0d, required %0d %0d",
                 v, cycles, idle, (v == 0) ? 17 : 18, (v == 0) ? 0 : 1);
      end
      vectors++;
      if (held_bad) begin
        miscompares++;
        $display("FAIL sweep_hold v=%0d: bcd changed before done, required hold at %h", v, prev);
      end
      prev = bcd;
      bin  = 16'(v + 1);
    end
    start = 1'b0;
  endtask

  task automatic test_start_ignored();
    int lat, ndone, first_lat;
    logic [19:0] cap;
    ndone = 0; first_lat = 0; cap = '0;
    @(negedge clk);
    start = 1'b1; bin = 16'd1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (lat = 2; lat <= 60; lat++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat == 6) begin start = 1'b1; bin = 16'd9999; end
      else            start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_lat = lat; cap = bcd; end
      end
    end
    start = 1'b0;
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL ignored_done_count: got %0d done pulses, required 1", ndone);
    end
    vectors++;
    if (first_lat !== 17 || cap !== 20'h01234) begin
      miscompares++;
      $display("FAIL ignored_result: lat=%0d bcd=%h, required 17 01234", first_lat, cap);
    end
  endtask

  task automatic test_reset_abort();
    int lat, ndone;
    @(negedge clk);
    start = 1'b1; bin = 16'd65535;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || bcd !== 20'h0) begin
      miscompares++;
      $display("FAIL abort_immediate: busy=%b done=%b ovf=%b bcd=%h, required 0 0 0 00000",
               busy, done, overflow, bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", ndone);
    end
    run_conv(1'b0, 16'd7, lat);
    vectors++;
    if (lat !== 17 || bcd !== 20'h00007 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort: lat=%0d bcd=%h ovf=%b, required 17 00007 0", lat, bcd, overflow);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_conv(1'b1, 16'd12345, lat);
    vectors++;
    if (lat !== 17 || bcd4 !== 16'h2345 || ovf4 !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_trunc: lat=%0d bcd=%h ovf=%b, required 17 2345 1", lat, bcd4, ovf4);
    end
    run_conv(1'b1, 16'd42, lat);
    vectors++;
    if (lat !== 17 || bcd4 !== 16'h0042 || ovf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: lat=%0d bcd=%h ovf=%b, required 17 0042 0", lat, bcd4, ovf4);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max_and_49();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the binary input width (range 4..32).
REQ-002 SHALL have parameter DIGITS, default 5, giving the number of BCD output digits (range 1..10).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, request to convert bin; sampled only in IDLE.
REQ-006 SHALL have port bin, input, WIDTH bits, unsigned binary operand, captured on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit, high while a conversion is in progress (SHIFT or DONE).
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse marking a valid new result.
REQ-009 SHALL have port bcd, output, 4*DIGITS bits; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
REQ-010 SHALL have port overflow, output, 1 bit, high when the last result did not fit in DIGITS digits.

Function
REQ-011 SHALL implement the double-dabble (shift-add-3) algorithm: one input bit per clock.
REQ-012 SHALL use the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: start=1 SHALL capture bin into a shift register, clear the working BCD register and the overflow accumulator, load iteration count WIDTH, and go to SHIFT.
REQ-014 SHIFT: each cycle SHALL add 3 to every working digit >=5, then shift {bcd_work, shreg} left by one.
- The iteration counter SHALL decrement each cycle.
- The FSM SHALL go to DONE after the WIDTH-th shift.
REQ-015 During SHIFT, a 1 shifted out of the top digit SHALL set the overflow accumulator (sticky until the next accepted start).
REQ-016 DONE: bcd and overflow SHALL be updated from the working registers, done SHALL be 1 for exactly this cycle, and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be WIDTH+1 cycles from the clk edge that samples start to the cycle in which done=1 (17 for WIDTH=16).
REQ-018 The bcd and overflow outputs SHALL hold their last result until the next DONE; they SHALL NOT change during SHIFT.
REQ-019 start SHALL be ignored while busy=1, including in the DONE cycle; the next conversion can be accepted no earlier than the cycle after done.
REQ-020 On overflow, bcd SHALL hold the correct low DIGITS digits of the decimal value (truncation, not saturation).
REQ-021 bin changes after the accepted start SHALL NOT affect the result.
REQ-022 Each output digit SHALL always be in the range 0..9.

Reset
REQ-023 rst_n=0 SHALL immediately force the following regardless of clk:
- FSM to IDLE, busy=0, done=0, overflow=0;
- bcd to all zeros;
- working registers and counter to zero.
REQ-024 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising clk edge.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state enumeration;
- the BCD digit width constant (4);
- the add-3 threshold constant (5);
- a helper giving the minimum digit count for a width (ceil(WIDTH*log10 2)).
REQ-027 A sub-module bcd_add3 (4-bit in, 4-bit out: in>=5 ? in+3 : in) SHALL be instantiated DIGITS times via generate.
REQ-028 An elaboration check SHALL report an error if WIDTH or DIGITS is outside its legal range.

Verification
REQ-029 Default parameters, bin=0, start pulse -> done after 17 cycles, bcd=0x00000, overflow=0.
REQ-030 Default parameters, bin=65535 -> bcd=0x65535, overflow=0; bin=49 -> bcd=0x00049.
REQ-031 Sweep bin=0..49 back-to-back, start asserted each cycle after done -> each result equals the decimal value, one done per request, busy low only between conversions.
REQ-032 bin=1234 started, start and bin=9999 driven again 5 cycles later -> second start ignored, bcd=0x01234, exactly one done.
REQ-033 rst_n pulsed low 8 cycles into a conversion of 65535 -> outputs zero immediately, no done; new start with bin=7 -> bcd=0x00007.
REQ-034 WIDTH=16, DIGITS=4, bin=12345 -> bcd=0x2345, overflow=1; next bin=42 -> bcd=0x0042, overflow=0.
